// File: rtl/fetch_inst_queue.sv
// Circular instruction queue between fetch and decode.
// Accepts up to four instructions per cycle and presents the four oldest.
module fetch_inst_queue #(
  parameter int DEPTH = 16,
  parameter int IW    = 16,
  parameter int PW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [2:0]    in_cnt,
  input  logic [IW-1:0] inst0,
  input  logic [IW-1:0] inst1,
  input  logic [IW-1:0] inst2,
  input  logic [IW-1:0] inst3,
  input  logic [PW-1:0] in_pc,
  output logic          in_ready,
  output logic [2:0]    out_cnt,
  output logic [IW-1:0] out_inst0,
  output logic [IW-1:0] out_inst1,
  output logic [IW-1:0] out_inst2,
  output logic [IW-1:0] out_inst3,
  output logic [PW-1:0] out_pc0,
  output logic [PW-1:0] out_pc1,
  output logic [PW-1:0] out_pc2,
  output logic [PW-1:0] out_pc3,
  input  logic [2:0]    out_take,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH - 4);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [IW-1:0] inst_mem [DEPTH];
  logic [PW-1:0] pc_mem   [DEPTH];

  logic [IW-1:0] in_inst   [4];
  logic [IW-1:0] head_inst [4];
  logic [PW-1:0] head_pc   [4];

  logic       push;
  logic [2:0] n_in;
  logic [2:0] n_out;

  assign in_inst[0] = inst0;
  assign in_inst[1] = inst1;
  assign in_inst[2] = inst2;
  assign in_inst[3] = inst3;

  assign in_ready = count <= LIMIT;
  assign empty    = count == '0;
  assign full     = count == (AW+1)'(DEPTH);

  // Flush wins: the incoming group is discarded.
  assign push  = in_valid && in_ready && !flush;
  assign n_in  = !push ? 3'd0 :
                 (in_cnt > 3'd4) ? 3'd4 : in_cnt;
  assign out_cnt = (count >= (AW+1)'(4)) ? 3'd4
                 : count[2:0];
  assign n_out = (out_take > out_cnt) ? out_cnt
               : out_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_in);
      rd_ptr <= rd_ptr + AW'(n_out);
      count  <= count + (AW+1)'(n_in)
              - (AW+1)'(n_out);
    end
  end

  // Entry storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_in) begin
        inst_mem[wr_ptr + AW'(i)] <= in_inst[i];
        pc_mem[wr_ptr + AW'(i)]   <= in_pc + PW'(i);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      head_inst[k] = '0;
      head_pc[k]   = '0;
      if (3'(k) < out_cnt) begin
        head_inst[k] = inst_mem[rd_ptr + AW'(k)];
        head_pc[k]   = pc_mem[rd_ptr + AW'(k)];
      end
    end
  end

  assign out_inst0 = head_inst[0];
  assign out_inst1 = head_inst[1];
  assign out_inst2 = head_inst[2];
  assign out_inst3 = head_inst[3];
  assign out_pc0   = head_pc[0];
  assign out_pc1   = head_pc[1];
  assign out_pc2   = head_pc[2];
  assign out_pc3   = head_pc[3];

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue.
// Reference model is a plain queue of (inst, pc) entries.
module tb_fetch_inst_queue;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_cnt = '0;
  logic [15:0] inst0 = '0, inst1 = '0;
  logic [15:0] inst2 = '0, inst3 = '0;
  logic [15:0] in_pc = '0;
  logic        in_ready;
  logic [2:0]  out_cnt;
  logic [15:0] out_inst0, out_inst1;
  logic [15:0] out_inst2, out_inst3;
  logic [15:0] out_pc0, out_pc1;
  logic [15:0] out_pc2, out_pc3;
  logic [2:0]  out_take = '0;
  logic        empty;
  logic        full;

  logic [15:0] oi [4];
  logic [15:0] op [4];

  ent_t mq[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 1'b0;

  fetch_inst_queue #(
    .DEPTH(DEPTH), .IW(16), .PW(16)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_cnt(in_cnt),
    .inst0(inst0), .inst1(inst1),
    .inst2(inst2), .inst3(inst3),
    .in_pc(in_pc), .in_ready(in_ready),
    .out_cnt(out_cnt),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_inst2(out_inst2), .out_inst3(out_inst3),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_pc2(out_pc2), .out_pc3(out_pc3),
    .out_take(out_take), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  assign oi[0] = out_inst0;
  assign oi[1] = out_inst1;
  assign oi[2] = out_inst2;
  assign oi[3] = out_inst3;
  assign op[0] = out_pc0;
  assign op[1] = out_pc1;
  assign op[2] = out_pc2;
  assign op[3] = out_pc3;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // Monitor: compare head against the model, then retire taken entries.
  always @(negedge clk) begin
    if (started && !rst) begin
      int vis;
      int n;
      vis = (mq.size() > 4) ? 4 : mq.size();
      chk("out_cnt", 32'(out_cnt), 32'(vis));
      chk("count", 32'(dut.count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("in_ready", 32'(in_ready),
          32'((DEPTH - mq.size()) >= 4));
      for (int k = 0; k < 4; k++) begin
        if (k < vis) begin
          chk($sformatf("inst%0d", k), 32'(oi[k]),
              32'(mq[k].inst));
          chk($sformatf("pc%0d", k), 32'(op[k]),
              32'(mq[k].pc));
        end else begin
          chk($sformatf("inst%0d_zero", k),
              32'(oi[k]), 32'h0);
          chk($sformatf("pc%0d_zero", k),
              32'(op[k]), 32'h0);
        end
      end
      n = (int'(out_take) < vis) ? int'(out_take) : vis;
      repeat (n) void'(mq.pop_front());
    end
  end

  // Drive one cycle of stimulus; model push/flush applied after the edge.
  task automatic cycle(input bit v,
                       input logic [2:0] c,
                       input logic [15:0] base,
                       input logic [15:0] pc,
                       input logic [2:0] take,
                       input bit fl);
    bit acc;
    int n;
    in_valid = v;
    in_cnt   = c;
    inst0    = base;
    inst1    = base + 16'd1;
    inst2    = base + 16'd2;
    inst3    = base + 16'd3;
    in_pc    = pc;
    out_take = take;
    flush    = fl;
    acc = v && !fl && ((DEPTH - mq.size()) >= 4);
    n   = (c > 3'd4) ? 4 : int'(c);
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else if (acc) begin
      for (int i = 0; i < n; i++) begin
        ent_t e;
        e.inst = base + 16'(i);
        e.pc   = pc + 16'(i);
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic [2:0] take);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, take, 1'b0);
  endtask

  initial begin
    logic [15:0] pcr;
    #12;
    chk("rst_out_cnt", 32'(out_cnt), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_inst0", 32'(out_inst0), 32'h0);
    chk("rst_pc3", 32'(out_pc3), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    // Single group, one-cycle latency.
    cycle(1'b1, 3'd4, 16'hA001, 16'h0010, 3'd0, 1'b0);
    chk("first_inst0", 32'(out_inst0), 32'hA001);
    chk("first_pc3", 32'(out_pc3), 32'h0013);
    chk("first_empty", 32'(empty), 32'h0);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1);

    // Fill to full, then a dropped group.
    for (int g = 0; g < 4; g++)
      cycle(1'b1, 3'd4, 16'h1000 + 16'(g * 4),
            16'h0100 + 16'(g * 4), 3'd0, 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_ready", 32'(in_ready), 32'h0);
    cycle(1'b1, 3'd4, 16'hBBBB, 16'h0200, 3'd0, 1'b0);
    repeat (4) idle(3'd4);
    chk("drain_empty", 32'(empty), 32'h1);

    // Steady state across the wrap point.
    pcr = 16'h0400;
    for (int g = 0; g < 22; g++) begin
      cycle(1'b1, 3'd4, 16'h2000 + 16'(g * 4), pcr,
            (g < 2) ? 3'd0 : 3'd4, 1'b0);
      pcr = pcr + 16'd4;
    end
    chk("steady_count", 32'(dut.count), 32'd8);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1);

    // Over-take with two entries.
    cycle(1'b1, 3'd2, 16'h3000, 16'h0500, 3'd0, 1'b0);
    chk("two_inst2", 32'(out_inst2), 32'h0);
    idle(3'd4);
    chk("overtake_count", 32'(dut.count), 32'h0);

    // Flush beats same-cycle push and pop.
    cycle(1'b1, 3'd4, 16'h4000, 16'h0600, 3'd0, 1'b0);
    cycle(1'b1, 3'd2, 16'h4004, 16'h0604, 3'd0, 1'b0);
    cycle(1'b1, 3'd3, 16'h4100, 16'h0700, 3'd2, 1'b1);
    chk("flush_out_cnt", 32'(out_cnt), 32'h0);
    chk("flush_empty", 32'(empty), 32'h1);

    // PC arithmetic wraps modulo 2^16.
    cycle(1'b1, 3'd4, 16'h5000, 16'hFFFE, 3'd0, 1'b0);
    chk("pcwrap_pc2", 32'(out_pc2), 32'h0000);
    chk("pcwrap_pc3", 32'(out_pc3), 32'h0001);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1);

    // Asynchronous reset with five entries queued.
    cycle(1'b1, 3'd4, 16'h6000, 16'h0800, 3'd0, 1'b0);
    cycle(1'b1, 3'd1, 16'h6004, 16'h0804, 3'd0, 1'b0);
    in_valid = 1'b0;
    out_take = 3'd0;
    chk("pre_rst_cnt", 32'(out_cnt), 32'd4);
    #2;
    rst = 1'b1;
    mq.delete();
    #1;
    chk("async_empty", 32'(empty), 32'h1);
    chk("async_out_cnt", 32'(out_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic, including clamped counts and rare flushes.
    for (int t = 0; t < 400; t++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            16'($urandom),
            16'($urandom),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 31) == 0));
    end
    repeat (6) idle(3'd4);

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
